// File: rtl/lcd_text_driver.sv
// lcd_text_driver: runs the HD44780 power-up/init sequence on a 16x2 character LCD, then
//   rewrites both rows whenever {line1,line2} differs from the last snapshot written.
// Latency: a change seen in IDLE starts a frame next cycle; first lcd_e rise one cycle later.
// Backpressure: none; a change during a frame sets pending and is written by the next frame.
// Ports: clk, rst (async active-low); line1/line2 text in ([127:120] = column 0);
//   lcd_e/lcd_rs/lcd_rw/lcd_data to the panel; busy (low only in IDLE); init_done (sticky).
// Option: define LCD_PERIODIC_REFRESH_EN to force a rewrite after REFRESH_CYC idle cycles.
module lcd_text_driver #(
    parameter int POWERUP_CYC = 750000,
    parameter int E_PULSE_CYC = 25,
    parameter int CMD_CYC     = 2500,
    parameter int CLEAR_CYC   = 100000,
    parameter int REFRESH_CYC = 5000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] line1,
    input  logic [127:0] line2,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data,
    output logic         busy,
    output logic         init_done
);
    // One counter serves power-up, slot timing and (optionally) idle timing, so it is
    // sized for the largest of them.
    localparam int MAX_AB   = (POWERUP_CYC > REFRESH_CYC) ? POWERUP_CYC : REFRESH_CYC;
    localparam int MAX_SLOT = E_PULSE_CYC + ((CLEAR_CYC > CMD_CYC) ? CLEAR_CYC : CMD_CYC);
    localparam int MAX_CNT  = (MAX_AB > MAX_SLOT) ? MAX_AB : MAX_SLOT;
    localparam int CW       = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] E_LAST   = CW'(E_PULSE_CYC);
    // Slot = 1 setup cycle + E_PULSE_CYC strobe cycles + wait; counter runs 0..LAST.
    localparam logic [CW-1:0] CMD_LAST = CW'(E_PULSE_CYC + CMD_CYC);
    localparam logic [CW-1:0] CLR_LAST = CW'(E_PULSE_CYC + CLEAR_CYC);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_IDLE,
        S_ADDR1,
        S_ROW1,
        S_ADDR2,
        S_ROW2
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [1:0]     step, step_n;      // init command index
    logic [3:0]     col, col_n;        // character column within a row
    logic [255:0]   snapshot;
    logic           pending;

    logic           changed;
    logic           refresh_hit;
    logic           frame_go;
    logic           init_fin;
    logic [CW-1:0]  slot_last;
    logic           slot_end;
    logic           writing_n;
    logic           e_n;
    logic           rs_n;
    logic [7:0]     data_n;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
            2'd1:    c = 8'h0C;   // display on, cursor off
            2'd2:    c = 8'h06;   // increment, no shift
            default: c = 8'h01;   // clear display
        endcase
        return c;
    endfunction

    assign changed   = ({line1, line2} != snapshot);
    assign slot_last = (state == S_INIT && step == 2'd3) ? CLR_LAST : CMD_LAST;
    assign slot_end  = (cnt == slot_last);
    assign busy      = (state != S_IDLE);
    assign lcd_rw    = 1'b0;

`ifdef LCD_PERIODIC_REFRESH_EN
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CYC - 1);
    logic [CW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (state == S_IDLE && !frame_go) begin
            idle_cnt <= idle_cnt + CNT_ONE;
        end else begin
            idle_cnt <= '0;
        end
    end

    assign refresh_hit = (idle_cnt == REF_LAST);
`else
    assign refresh_hit = 1'b0;
`endif

    // Next-state logic, plus the output values that go with the next state so the
    // panel pins come straight from flops.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        step_n   = step;
        col_n    = col;
        frame_go = 1'b0;
        init_fin = 1'b0;

        case (state)
            S_PWRUP: begin
                if (cnt == PWR_LAST) begin
                    state_n = S_INIT;
                    cnt_n   = '0;
                    step_n  = 2'd0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            S_INIT: begin
                if (slot_end) begin
                    cnt_n = '0;
                    if (step == 2'd3) begin
                        state_n  = S_IDLE;
                        init_fin = 1'b1;
                    end else begin
                        step_n = step + 2'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            S_IDLE: begin
                cnt_n = '0;
                if (pending || changed || refresh_hit) begin
                    frame_go = 1'b1;
                    state_n  = S_ADDR1;
                end
            end
            S_ADDR1: begin
                if (slot_end) begin
                    state_n = S_ROW1;
                    cnt_n   = '0;
                    col_n   = 4'd0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            S_ROW1: begin
                if (slot_end) begin
                    cnt_n = '0;
                    col_n = col + 4'd1;
                    if (col == 4'd15) begin
                        state_n = S_ADDR2;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            S_ADDR2: begin
                if (slot_end) begin
                    state_n = S_ROW2;
                    cnt_n   = '0;
                    col_n   = 4'd0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            S_ROW2: begin
                if (slot_end) begin
                    cnt_n = '0;
                    col_n = col + 4'd1;
                    if (col == 4'd15) begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = S_PWRUP;
                cnt_n   = '0;
            end
        endcase

        // Output values for the upcoming cycle. Snapshot is already latched by the
        // time a ROW state is entered, so the current register is the right source.
        writing_n = (state_n != S_PWRUP) && (state_n != S_IDLE);
        e_n       = writing_n && (cnt_n != '0) && (cnt_n <= E_LAST);
        rs_n      = 1'b0;
        data_n    = 8'h00;
        case (state_n)
            S_INIT:  data_n = init_cmd(step_n);
            S_ADDR1: data_n = 8'h80;
            S_ROW1: begin
                rs_n   = 1'b1;
                // Row 0 lives in snapshot[255:128]; column c starts at bit 255-8c.
                data_n = snapshot[{1'b1, ~col_n, 3'b111} -: 8];
            end
            S_ADDR2: data_n = 8'hC0;
            S_ROW2: begin
                rs_n   = 1'b1;
                data_n = snapshot[{1'b0, ~col_n, 3'b111} -: 8];
            end
            default: begin
                rs_n   = 1'b0;
                data_n = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_PWRUP;
            cnt   <= '0;
            step  <= 2'd0;
            col   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            step  <= step_n;
            col   <= col_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            init_done <= 1'b0;
            pending   <= 1'b0;
            snapshot  <= {32{8'h20}};
        end else begin
            lcd_e    <= e_n;
            lcd_rs   <= rs_n;
            lcd_data <= data_n;
            if (init_fin) begin
                init_done <= 1'b1;
            end
            if (frame_go) begin
                snapshot <= {line1, line2};
                pending  <= 1'b0;
            end else if (init_fin) begin
                // Forces the first frame straight after init, whatever the text is.
                pending <= 1'b1;
            end else if (busy && state != S_PWRUP && state != S_INIT && changed) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: doc/lcd_text_driver.md
# lcd_text_driver

Sequences a 16x2 HD44780-compatible character LCD from the two 128-bit text buffers produced by the game's display formatter. Runs the LCD power-up/init command sequence, then rewrites both rows whenever the buffer contents change. Sits between the display formatter and the board's LCD pins. It is the only block that drives the LCD bus.

## Interface
- POWERUP_CYC, 750000: idle cycles after reset release before the first command (≥15 ms at 50 MHz).
- E_PULSE_CYC, 25: cycles `lcd_e` is held high per write.
- CMD_CYC, 2500: post-pulse wait after a normal command or character write.
- CLEAR_CYC, 100000: post-pulse wait after the clear-display command (0x01).
- REFRESH_CYC, 5000000: idle cycles between forced rewrites; used only with the config macro.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- line1  in  128  row-0 text; [127:120] is column 0, [7:0] is column 15.
- line2  in  128  row-1 text, same packing.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_rw  out  1  tied 0 (write only).
- lcd_data  out  8  LCD data bus.
- busy  out  1  1 while init or a frame write is in progress.
- init_done  out  1  1 once the init sequence has completed; stays 1 until reset.

## Operation
- **States:** PWRUP → INIT → IDLE → ADDR1 → ROW1 → ADDR2 → ROW2 → IDLE.
- **PWRUP:** counts POWERUP_CYC cycles with all outputs at their reset values.
- **INIT:** issues commands in order 0x38, 0x0C, 0x06, 0x01 with `rs`=0. The clear command (0x01) uses the CLEAR_CYC wait. Then `init_done`=1 and the block goes to IDLE.
- **Frame start:**
  - Entering IDLE from INIT starts the first frame immediately.
  - Otherwise a frame starts when `{line1,line2}` differs from the snapshot, or when `pending`=1.
  - On frame start, `{line1,line2}` is latched into a 256-bit snapshot and `pending` is cleared.
- **Frame contents:**
  - ADDR1 writes 0x80 (`rs`=0).
  - ROW1 writes snapshot row-0 characters for columns 0..15 (`rs`=1).
  - ADDR2 writes 0xC0 (`rs`=0).
  - ROW2 writes row-1 characters for columns 0..15.
  - 34 writes per frame in total.
- **Write slot (one per write):**
  - Cycle 0: `rs` and `lcd_data` driven, `e`=0.
  - Next E_PULSE_CYC cycles: `e`=1.
  - Then `e`=0 for the wait count (CMD_CYC or CLEAR_CYC).
  - `rs` and `lcd_data` are stable for the whole slot.
- **Input change during a frame:** if `{line1,line2}` differs from the snapshot during a frame, `pending` is set. The current frame completes with the old snapshot, and the next frame starts on the cycle after returning to IDLE.
- **Character bytes:** no substitution; bytes are passed to the LCD unmodified.
- **busy:** 1 in PWRUP, INIT, ADDR1..ROW2; 0 only in IDLE.
- **Counters:** sized to the largest parameter value. Column index is 4 bits and wraps from 15 to the next state.

## Timing
- **Reset values:** `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `busy`=1, `init_done`=0, `pending`=0, snapshot all 0x20.
- **Reset mid-operation:** `rst` low at any cycle forces reset values immediately (asynchronous). Release restarts from PWRUP, including the full init sequence.
- **Slot length:** 1+E_PULSE_CYC+CMD_CYC cycles, or 1+E_PULSE_CYC+CLEAR_CYC for the clear command.
- **Frame length:** 34×(1+E_PULSE_CYC+CMD_CYC) cycles.
- **Change-to-start latency:** an input change seen in IDLE starts the frame next cycle; the first `e` rise follows 1 cycle later.
- **Change detection timing:** a change and a return to IDLE in the same cycle count as a change; the frame starts on the next cycle.
- **Input synchronisation:** inputs are assumed synchronous to `clk`; no CDC logic.

## Configuration
- **LCD_PERIODIC_REFRESH_EN defined:**
  - An idle counter runs in IDLE and clears on leaving IDLE.
  - When it reaches REFRESH_CYC, a frame starts even if the contents are unchanged. This recovers from LCD glitches.
- **LCD_PERIODIC_REFRESH_EN undefined:** frames start only on content change or `pending`; REFRESH_CYC is ignored.

## Test plan
All scenarios use POWERUP_CYC=20, E_PULSE_CYC=2, CMD_CYC=4, CLEAR_CYC=10, REFRESH_CYC=300.

- **Reset and init:** hold `rst`=0 10 cycles, release → outputs at reset values for 20 cycles. Then `e` pulses carry 0x38, 0x0C, 0x06 (7 cycles each) and 0x01 (13 cycles), `rs`=0. `init_done` rises after 34 init cycles.
- **First frame:** `line1`="PRESS * TO START", `line2`="MONEY: 01000    " → 34 pulses: 0x80, 16 row-0 bytes with `rs`=1, 0xC0, 16 row-1 bytes. Frame is 238 cycles, then `busy`=0.
- **Change in IDLE:** change one byte of `line2` → `busy`=1 next cycle; a new 238-cycle frame carries the new byte at the correct position.
- **Change mid-frame:** change `line1` at the 5th row-0 character → current frame still outputs old text, then the next frame starts 1 cycle after IDLE with the new text.
- **Reset mid-frame:** pull `rst` low during ROW2 → `e`=0, `data`=0, `busy`=1, `init_done`=0 immediately. After release the full init replays.
- **Periodic refresh:** static inputs with LCD_PERIODIC_REFRESH_EN defined → a frame restarts every 300 idle cycles. With the macro undefined → no further `e` pulses after the first frame.
